// File: rtl/rgb_window_generator.sv
`default_nettype none
// ============================================================================
// Module      : rgb_window_generator
// Description : Turns a raster-order RGB pixel stream into a sliding 3x3 RGB
//               window. Two line buffers hold the previous two lines and a
//               3x3 register array holds the window. A window is emitted,
//               one clock after the accept, only for fully interior positions
//               (row>=2, col>=2). There is no border padding.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid/in_ready     - input pixel handshake
//               in_sof                - accepted pixel is position (0,0)
//               in_red/green/blue     - input pixel channels
//               out_valid/out_ready   - window handshake
//               out_last              - final window of the frame
//               pixel_k_red/green/blue (k=0..8) - window pixel k=3*r+c,
//                                       k=0 top-left, k=8 bottom-right
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_window_generator #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int IMAGE_WIDTH   = 64,
    parameter int IMAGE_HEIGHT  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [BIT_PER_PIXEL-1:0] in_red,
    input  logic [BIT_PER_PIXEL-1:0] in_green,
    input  logic [BIT_PER_PIXEL-1:0] in_blue,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [BIT_PER_PIXEL-1:0] pixel_0_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_0_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_0_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_1_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_1_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_1_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_2_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_2_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_2_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_3_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_3_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_3_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_4_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_4_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_4_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_5_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_5_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_5_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_6_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_6_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_6_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_7_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_7_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_7_blue,
    output logic [BIT_PER_PIXEL-1:0] pixel_8_red,
    output logic [BIT_PER_PIXEL-1:0] pixel_8_green,
    output logic [BIT_PER_PIXEL-1:0] pixel_8_blue
);

    localparam int BPP = BIT_PER_PIXEL;
    localparam int PW  = 3 * BPP;                 // packed {red, green, blue}
    localparam int CW  = $clog2(IMAGE_WIDTH);
    localparam int RW  = $clog2(IMAGE_HEIGHT);

    localparam logic [CW-1:0] c_COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
    localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [PW-1:0] r_line0 [IMAGE_WIDTH];   // line row-2
    logic [PW-1:0] r_line1 [IMAGE_WIDTH];   // line row-1
    logic [PW-1:0] r_win   [9];
    logic [PW-1:0] r_out   [9];
    logic          r_out_valid;
    logic          r_out_last;

    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic [PW-1:0] w_pix;
    logic [PW-1:0] w_lb0_rd;
    logic [PW-1:0] w_lb1_rd;
    logic [PW-1:0] w_win_nxt [9];
    logic          w_emit;
    logic          w_is_last;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // in_sof overrides the tracked position so a mid-frame stream resyncs.
    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;

    assign w_pix    = {in_red, in_green, in_blue};
    assign w_lb0_rd = r_line0[w_col];
    assign w_lb1_rd = r_line1[w_col];

    assign w_emit    = w_accept && (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);
    assign w_is_last = (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);

    always_comb begin
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_col == c_COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_ROW_LAST) ? '0 : w_row + RW'(1);
        end
    end

    // Window shifted left by one column with the fresh column on the right.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[3*r]     = r_win[3*r + 1];
            w_win_nxt[3*r + 1] = r_win[3*r + 2];
            w_win_nxt[3*r + 2] = '0;
        end
        w_win_nxt[2] = w_lb0_rd;
        w_win_nxt[5] = w_lb1_rd;
        w_win_nxt[8] = w_pix;
    end

    // Line buffers are plain storage; stale content is masked by row/col gating.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line0[w_col] <= w_lb1_rd;
            r_line1[w_col] <= w_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
                r_out[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int k = 0; k < 9; k++) begin
                    r_win[k] <= w_win_nxt[k];
                end
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_is_last;
                for (int k = 0; k < 9; k++) begin
                    r_out[k] <= w_win_nxt[k];
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    assign {pixel_0_red, pixel_0_green, pixel_0_blue} = r_out[0];
    assign {pixel_1_red, pixel_1_green, pixel_1_blue} = r_out[1];
    assign {pixel_2_red, pixel_2_green, pixel_2_blue} = r_out[2];
    assign {pixel_3_red, pixel_3_green, pixel_3_blue} = r_out[3];
    assign {pixel_4_red, pixel_4_green, pixel_4_blue} = r_out[4];
    assign {pixel_5_red, pixel_5_green, pixel_5_blue} = r_out[5];
    assign {pixel_6_red, pixel_6_green, pixel_6_blue} = r_out[6];
    assign {pixel_7_red, pixel_7_green, pixel_7_blue} = r_out[7];
    assign {pixel_8_red, pixel_8_green, pixel_8_blue} = r_out[8];

endmodule
`default_nettype wire
